// File: rtl/fulladder_serial_arb.sv
// fulladder_serial_arb
// Round-robin scheduler that time-shares one external combinational 1-bit
// full-adder slice between two requesters. Each accepted request is added
// bit-serially, LSB first, one bit per clock, and returned on a
// valid/ready response port.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req{0,1}_valid/_ready      request handshake (ready is combinational)
//   req{0,1}_a/_b/_cin         operands and carry-in
//   rsp_valid/rsp_ready        response handshake
//   rsp_sum/rsp_cout/rsp_id    result, carry-out, owning requester
//   fa_x/fa_y/fa_cin           drive the full-adder slice inputs
//   fa_sum/fa_cout             full-adder slice outputs (same cycle)
module fulladder_serial_arb #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
    output logic             fa_x,
    output logic             fa_y,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic               carry;
    logic               id;
    logic               last_id;
    logic [CNT_W-1:0]   bit_cnt;

    logic               grant;
    logic               any_valid;
    logic               accept;

    // Round-robin grant: a tie goes to the requester not served last.
    always_comb begin
        grant     = 1'b0;
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_id;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Readys are held low during reset even though state already reads IDLE.
    assign accept     = rst_n && (state == IDLE) && any_valid;
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    // Slice inputs are only driven while a bit is being processed.
    assign fa_x   = (state == RUN) & a_sh[0];
    assign fa_y   = (state == RUN) & b_sh[0];
    assign fa_cin = (state == RUN) & carry;

    assign rsp_sum  = sum_sh;
    assign rsp_cout = carry;
    assign rsp_id   = id;

    // Control FSM and serial datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            id        <= 1'b0;
            last_id   <= 1'b1;
            bit_cnt   <= '0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh    <= grant ? req1_a : req0_a;
                        b_sh    <= grant ? req1_b : req0_b;
                        carry   <= grant ? req1_cin : req0_cin;
                        id      <= grant;
                        bit_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_sh  <= {fa_sum, sum_sh[WIDTH-1:1]};
                    carry   <= fa_cout;
                    a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        last_id   <= id;
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fulladder_serial_arb.sv
module tb_fulladder_serial_arb;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_cin;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_cout, rsp_id;
    logic [W-1:0] rsp_sum;
    logic         fa_x, fa_y, fa_cin, fa_sum, fa_cout;

    int checks   = 0;
    int failures = 0;
    int last_id  = 1;

    // Behavioural full-adder slice.
    assign {fa_cout, fa_sum} = 2'(fa_x) + 2'(fa_y) + 2'(fa_cin);

    fulladder_serial_arb #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id),
        .fa_x       (fa_x),
        .fa_y       (fa_y),
        .fa_cin     (fa_cin),
        .fa_sum     (fa_sum),
        .fa_cout    (fa_cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy0"}, 32'(req0_ready), 0);
        check({tag, "_rdy1"}, 32'(req1_ready), 0);
        check({tag, "_vld"},  32'(rsp_valid), 0);
        check({tag, "_sum"},  32'(rsp_sum), 0);
        check({tag, "_cout"}, 32'(rsp_cout), 0);
        check({tag, "_id"},   32'(rsp_id), 0);
        check({tag, "_fa"},   32'({fa_x, fa_y, fa_cin}), 0);
    endtask

    // One complete transaction, called one cycle-phase after a rising edge
    // with the DUT in IDLE. pat: 1 = req0 only, 2 = req1 only, 3 = both.
    task automatic run_txn(input int pat,
                           input logic [W-1:0] a0, input logic [W-1:0] b0, input logic c0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1, input logic c1,
                           input int bp, input bit hold);
        int g;
        int ea, eb, ec, full, m, cin_i;
        logic [W-1:0] s_sum;
        g = (pat == 1) ? 0 : (pat == 2) ? 1 : (last_id == 1 ? 0 : 1);
        req0_a = a0; req0_b = b0; req0_cin = c0;
        req1_a = a1; req1_b = b1; req1_cin = c1;
        req0_valid = (pat != 2);
        req1_valid = (pat != 1);
        rsp_ready  = (bp == 0);
        #1;
        check("grant_rdy0", 32'(req0_ready), 32'(g == 0));
        check("grant_rdy1", 32'(req1_ready), 32'(g == 1));
        tick();
        if (!hold) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        ea = (g == 0) ? int'(a0) : int'(a1);
        eb = (g == 0) ? int'(b0) : int'(b1);
        ec = (g == 0) ? int'(c0) : int'(c1);
        full = ea + eb + ec;
        for (int i = 0; i < int'(W); i++) begin
            m = (1 << i) - 1;
            cin_i = (((ea & m) + (eb & m) + ec) >> i) & 1;
            check("run_fa_x",   32'(fa_x),   32'((ea >> i) & 1));
            check("run_fa_y",   32'(fa_y),   32'((eb >> i) & 1));
            check("run_fa_cin", 32'(fa_cin), 32'(cin_i));
            check("run_vld",    32'(rsp_valid), 0);
            check("run_rdy",    32'({req0_ready, req1_ready}), 0);
            tick();
        end
        check("done_vld",  32'(rsp_valid), 1);
        check("done_sum",  32'(rsp_sum), 32'(full & ((1 << W) - 1)));
        check("done_cout", 32'(rsp_cout), 32'((full >> W) & 1));
        check("done_id",   32'(rsp_id), 32'(g));
        check("done_fa",   32'({fa_x, fa_y, fa_cin}), 0);
        s_sum = rsp_sum;
        for (int k = 0; k < bp; k++) begin
            tick();
            check("bp_vld",  32'(rsp_valid), 1);
            check("bp_sum",  32'(rsp_sum), 32'(full & ((1 << W) - 1)));
            check("bp_cout", 32'(rsp_cout), 32'((full >> W) & 1));
            check("bp_id",   32'(rsp_id), 32'(g));
            check("bp_rdy",  32'({req0_ready, req1_ready}), 0);
            check("bp_fa",   32'({fa_x, fa_y, fa_cin}), 0);
        end
        rsp_ready = 1'b1;
        tick();
        check("hs_vld", 32'(rsp_valid), 0);
        last_id = g;
        if (s_sum !== rsp_sum) begin end
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        rsp_ready = 1'b1;
        #2;
        check_all_zero("reset");
        tick();
        tick();
        check_all_zero("reset_hold");
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Directed: main example and carry boundaries.
        run_txn(1, 8'h5A, 8'h33, 1'b0, 8'h00, 8'h00, 1'b0, 0, 0);
        run_txn(1, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 0, 0);
        run_txn(2, 8'h00, 8'h00, 1'b0, 8'hFF, 8'hFF, 1'b1, 0, 0);
        run_txn(1, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 0, 0);

        // Both valid continuously: grants alternate.
        for (int t = 0; t < 4; t++)
            run_txn(3, 8'h01, 8'h02, 1'b0, 8'h10, 8'h20, 1'b0, 0, 1);

        // Response backpressure.
        run_txn(3, 8'h7E, 8'h81, 1'b1, 8'hC3, 8'h3C, 1'b1, 5, 0);

        // Reset mid-RUN after three bit edges.
        req0_valid = 1'b1; req0_a = 8'hAA; req0_b = 8'h55; req0_cin = 1'b1;
        #1;
        tick();
        tick(); tick(); tick();
        req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_rst");
        tick();
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        last_id = 1;
        for (int k = 0; k < int'(W) + 2; k++) begin
            check("post_rst_vld", 32'(rsp_valid), 0);
            tick();
        end
        run_txn(3, 8'h12, 8'h34, 1'b0, 8'h56, 8'h78, 1'b1, 0, 0);

        // Randomized traffic against the arithmetic/round-robin model.
        for (int t = 0; t < 40; t++) begin
            run_txn(int'($urandom_range(1, 3)),
                    W'($urandom), W'($urandom), 1'($urandom),
                    W'($urandom), W'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Readys must never be asserted together.
    always @(negedge clk) begin
        if (req0_ready && req1_ready) begin
            failures++;
            $display("FAIL both_ready got=11 exp=not-both @%0t", $time);
        end
    end

endmodule
